// File: rtl/rgb_gauss_3x3.sv
// rgb_gauss_3x3
// Streaming 3x3 Gaussian low-pass filter ([1 2 1; 2 4 2; 1 2 1] / 16) for
// RGB565 video on a DE/VS/HS pixel bus. Two cascaded line buffers supply the
// two previous lines; each colour channel is filtered independently.
// Output for input position (r, c) is the filtered pixel centred on
// (r-1, c-1); taps outside the current frame are zero.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_hs     in   horizontal sync, delay-matched only (tie to 0 if unused)
//   in_vs     in   vertical sync, active high, clears the row counter
//   in_de     in   data enable, in_data valid when high
//   in_data   in   RGB565 pixel {R[15:11], G[10:5], B[4:0]}
//   out_hs    out  in_hs delayed by 4 clocks
//   out_vs    out  in_vs delayed by 4 clocks
//   out_de    out  in_de delayed by 4 clocks
//   out_data  out  filtered RGB565 pixel, 0 while out_de is low
module rgb_gauss_3x3 #(
  parameter int H_ACTIVE  = 800,
  parameter int RGB_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_hs,
  input  logic                 in_vs,
  input  logic                 in_de,
  input  logic [RGB_WIDTH-1:0] in_data,
  output logic                 out_hs,
  output logic                 out_vs,
  output logic                 out_de,
  output logic [RGB_WIDTH-1:0] out_data
);

  localparam int unsigned CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  // Column sum of one window column: {R 7b, G 8b, B 7b}, weights 1/2/1
  // top/middle/bottom, each tap zeroed when its validity bit is low.
  function automatic logic [21:0] f_colsum(
    input logic [15:0] t, input logic [15:0] m, input logic [15:0] b,
    input logic vt, input logic vm, input logic vb
  );
    logic [15:0] tt, mm, bb;
    tt = vt ? t : '0;
    mm = vm ? m : '0;
    bb = vb ? b : '0;
    f_colsum = {7'(tt[15:11]) + 7'({mm[15:11], 1'b0}) + 7'(bb[15:11]),
                8'(tt[10:5])  + 8'({mm[10:5],  1'b0}) + 8'(bb[10:5]),
                7'(tt[4:0])   + 7'({mm[4:0],   1'b0}) + 7'(bb[4:0])};
  endfunction

  // Counters and sync delay lines
  logic [CW-1:0] r_col;
  logic [1:0]    r_row;
  logic [3:0]    r_de_d;
  logic [3:0]    r_vs_d;
  logic [3:0]    r_hs_d;

  // Line buffers (not reset; invalid taps are masked instead)
  logic [RGB_WIDTH-1:0] r_lb1 [H_ACTIVE];
  logic [RGB_WIDTH-1:0] r_lb2 [H_ACTIVE];
  logic [RGB_WIDTH-1:0] w_lb1_rd;
  logic [RGB_WIDTH-1:0] w_lb2_rd;

  // Stage 1: window, index 0 = column c-2, 2 = column c
  logic [15:0] r_w_top [3];   // row r-2
  logic [15:0] r_w_mid [3];   // row r-1
  logic [15:0] r_w_bot [3];   // row r
  logic        r_s1_rv1, r_s1_rv2, r_s1_cv1, r_s1_cv2;

  // Stage 2: weighted column sums
  logic [21:0] w_cs0, w_cs1, w_cs2;
  logic [21:0] r_cs0, r_cs1, r_cs2;

  // Stage 3: full sums
  logic [8:0]  r_sr;
  logic [9:0]  r_sg;
  logic [8:0]  r_sb;

  // Stage 4: rounding and output
  logic [8:0]  w_rnd_r;
  logic [9:0]  w_rnd_g;
  logic [8:0]  w_rnd_b;
  logic [RGB_WIDTH-1:0] r_out_data;

  // Row validity for the pixel on the bus; in_vs forces row 0 this cycle
  logic w_rv1, w_rv2, w_cv1, w_cv2;

  assign w_lb1_rd = r_lb1[r_col];
  assign w_lb2_rd = r_lb2[r_col];

  assign w_rv1 = !in_vs && (r_row != 2'd0);
  assign w_rv2 = !in_vs && (r_row == 2'd2);
  assign w_cv1 = (r_col != '0);
  assign w_cv2 = (r_col > CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_de_d <= '0;
      r_vs_d <= '0;
      r_hs_d <= '0;
    end else begin
      r_de_d <= {r_de_d[2:0], in_de};
      r_vs_d <= {r_vs_d[2:0], in_vs};
      r_hs_d <= {r_hs_d[2:0], in_hs};

      if (in_de) begin
        if (r_col != CW'(H_ACTIVE - 1))
          r_col <= r_col + CW'(1);
      end else begin
        r_col <= '0;
      end

      // r_de_d[0] is last cycle's in_de, so this is the DE falling edge
      if (in_vs)
        r_row <= '0;
      else if (r_de_d[0] && !in_de && (r_row != 2'd2))
        r_row <= r_row + 2'd1;
    end
  end

  // Read-before-write: buf2 takes the line buf1 held before this write
  always_ff @(posedge clk) begin
    if (in_de) begin
      r_lb1[r_col] <= in_data;
      r_lb2[r_col] <= w_lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_top  <= '{default: '0};
      r_w_mid  <= '{default: '0};
      r_w_bot  <= '{default: '0};
      r_s1_rv1 <= 1'b0;
      r_s1_rv2 <= 1'b0;
      r_s1_cv1 <= 1'b0;
      r_s1_cv2 <= 1'b0;
    end else if (in_de) begin
      r_w_top[0] <= r_w_top[1];
      r_w_top[1] <= r_w_top[2];
      r_w_top[2] <= w_lb2_rd[15:0];
      r_w_mid[0] <= r_w_mid[1];
      r_w_mid[1] <= r_w_mid[2];
      r_w_mid[2] <= w_lb1_rd[15:0];
      r_w_bot[0] <= r_w_bot[1];
      r_w_bot[1] <= r_w_bot[2];
      r_w_bot[2] <= in_data[15:0];
      r_s1_rv1   <= w_rv1;
      r_s1_rv2   <= w_rv2;
      r_s1_cv1   <= w_cv1;
      r_s1_cv2   <= w_cv2;
    end
  end

  assign w_cs0 = f_colsum(r_w_top[0], r_w_mid[0], r_w_bot[0],
                          r_s1_rv2 && r_s1_cv2, r_s1_rv1 && r_s1_cv2, r_s1_cv2);
  assign w_cs1 = f_colsum(r_w_top[1], r_w_mid[1], r_w_bot[1],
                          r_s1_rv2 && r_s1_cv1, r_s1_rv1 && r_s1_cv1, r_s1_cv1);
  assign w_cs2 = f_colsum(r_w_top[2], r_w_mid[2], r_w_bot[2],
                          r_s1_rv2, r_s1_rv1, 1'b1);

  assign w_rnd_r = r_sr + 9'd8;
  assign w_rnd_g = r_sg + 10'd8;
  assign w_rnd_b = r_sb + 9'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs0      <= '0;
      r_cs1      <= '0;
      r_cs2      <= '0;
      r_sr       <= '0;
      r_sg       <= '0;
      r_sb       <= '0;
      r_out_data <= '0;
    end else begin
      r_cs0 <= w_cs0;
      r_cs1 <= w_cs1;
      r_cs2 <= w_cs2;

      r_sr <= 9'(r_cs0[21:15]) + 9'({r_cs1[21:15], 1'b0}) + 9'(r_cs2[21:15]);
      r_sg <= 10'(r_cs0[14:7]) + 10'({r_cs1[14:7], 1'b0}) + 10'(r_cs2[14:7]);
      r_sb <= 9'(r_cs0[6:0])   + 9'({r_cs1[6:0],   1'b0}) + 9'(r_cs2[6:0]);

      // r_de_d[2] is the DE of the pixel now leaving stage 3
      if (r_de_d[2])
        r_out_data <= RGB_WIDTH'({w_rnd_r[8:4], w_rnd_g[9:4], w_rnd_b[8:4]});
      else
        r_out_data <= '0;
    end
  end

  assign out_de   = r_de_d[3];
  assign out_vs   = r_vs_d[3];
  assign out_hs   = r_hs_d[3];
  assign out_data = r_out_data;

endmodule

// File: tb/tb_rgb_gauss_3x3.sv
// Testbench for rgb_gauss_3x3: drives small frames, keeps a frame image and
// an independent 3x3 reference model, and compares every output cycle.
module tb_rgb_gauss_3x3;

  localparam int H    = 12;
  localparam int ROWS = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_hs, in_vs, in_de;
  logic [15:0] in_data;
  logic        out_hs, out_vs, out_de;
  logic [15:0] out_data;

  rgb_gauss_3x3 #(.H_ACTIVE(H), .RGB_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    int          c;
    logic [15:0] e;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] img [0:ROWS-1][0:H-1];
  logic [15:0] obs [0:ROWS-1][0:H-1];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: filtered pixel centred on (r-1, c-1) from the current frame image
  function automatic logic [15:0] model(input int r, input int c);
    int sr = 0, sg = 0, sb_ = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        int rr = r - 2 + dr;
        int cc = c - 2 + dc;
        int w  = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
        logic [15:0] p;
        if (rr >= 0 && cc >= 0) begin
          p   = img[rr][cc];
          sr  += w * int'(p[15:11]);
          sg  += w * int'(p[10:5]);
          sb_ += w * int'(p[4:0]);
        end
      end
    end
    return {5'((sr + 8) / 16), 6'((sg + 8) / 16), 5'((sb_ + 8) / 16)};
  endfunction

  function automatic logic [15:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 16'hFFFF;
      1:       return (r == 5 && c == 5) ? 16'h8000 : 16'h0000;
      2:       return {5'd0, 6'(c % 64), 5'd0};
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_pix(input int r, input int c, input logic [15:0] d, input logic vs);
    sb_t e;
    in_de   = 1'b1;
    in_vs   = vs;
    in_hs   = 1'b0;
    in_data = d;
    img[r][c] = d;
    e.r = r;
    e.c = c;
    e.e = model(r, c);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic vs, input logic hs);
    for (int i = 0; i < n; i++) begin
      in_de   = 1'b0;
      in_vs   = vs;
      in_hs   = hs;
      in_data = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input int pat, input int blank, input bit hs_en, input bit vs_cc);
    if (!vs_cc) begin
      idle(2, 1'b1, 1'b0);
      idle(1, 1'b0, 1'b0);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < H; c++)
        drive_pix(r, c, pix(pat, r, c), vs_cc && r == 0 && c == 0);
      for (int b = 0; b < blank; b++)
        idle(1, 1'b0, hs_en && b == 0);
    end
    idle(8, 1'b0, 1'b0);
  endtask

  // Output monitor: sync/DE delay model plus scoreboard pop
  initial begin
    logic [3:0] h_de, h_vs, h_hs;
    sb_t e;
    h_de = '0; h_vs = '0; h_hs = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        h_de = '0; h_vs = '0; h_hs = '0;
      end else begin
        h_de = {h_de[2:0], in_de};
        h_vs = {h_vs[2:0], in_vs};
        h_hs = {h_hs[2:0], in_hs};
      end
      #2;
      check("out_de", 32'(out_de), 32'(h_de[3]));
      check("out_vs", 32'(out_vs), 32'(h_vs[3]));
      check("out_hs", 32'(out_hs), 32'(h_hs[3]));
      if (h_de[3]) begin
        check("sb_level", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check($sformatf("data(%0d,%0d)", e.r, e.c), 32'(out_data), 32'(e.e));
          obs[e.r][e.c] = out_data;
        end
      end else begin
        check("idle_data", 32'(out_data), 32'd0);
      end
    end
  end

  initial begin
    logic [15:0] v;
    rst_n = 1'b0; in_de = 1'b0; in_vs = 1'b0; in_hs = 1'b0; in_data = '0;
    // Reset held with DE toggling: outputs must stay 0
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_de   = ~in_de;
      in_vs   = in_de;
      in_hs   = ~in_de;
      in_data = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_de = 1'b0; in_vs = 1'b0; in_hs = 1'b0;
    idle(2, 1'b0, 1'b0);

    // Mid-frame start after reset: first line is row 0
    for (int c = 0; c < H; c++) drive_pix(0, c, pix(4, 0, c), 1'b0);
    idle(3, 1'b0, 1'b1);

    // Constant white frame, 1-clock blanking
    frame(0, 1, 1'b1, 1'b0);
    // only the bottom-right corner tap is valid at (0,0): (31+8)>>4 = 2, (63+8)>>4 = 4
    check("white(0,0)", 32'(obs[0][0]), 32'h1082);
    check("white(0,5)", 32'(obs[0][5]), 32'h4208);
    check("white(4,5)", 32'(obs[4][5]), 32'hFFFF);
    check("white(9,11)", 32'(obs[9][11]), 32'hFFFF);

    // All-zero frame right after white: no stale energy in rows 0-1
    frame(3, 3, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < H; c++)
        check($sformatf("stale(%0d,%0d)", r, c), 32'(obs[r][c]), 32'h0);

    // Impulse R=16 at (5,5)
    frame(1, 2, 1'b1, 1'b0);
    check("imp(6,6)", 32'(obs[6][6]), 32'h2000);
    check("imp(6,7)", 32'(obs[6][7]), 32'h1000);
    check("imp(7,7)", 32'(obs[7][7]), 32'h0800);
    check("imp(8,8)", 32'(obs[8][8]), 32'h0000);

    // Green ramp: interior G equals column c-1 exactly
    frame(2, 1, 1'b1, 1'b0);
    for (int r = 2; r < ROWS; r++)
      for (int c = 2; c < H; c++) begin
        v = obs[r][c];
        check($sformatf("ramp(%0d,%0d)", r, c), 32'(v[10:5]), 32'(c - 1));
      end

    // Random frame, VS concurrent with first pixel, HS held low
    frame(4, 2, 1'b0, 1'b1);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
